// File: rtl/cl_tcdm2axi_bridge.sv
// TCDM-to-AXI bridge: converts single 32-bit TCDM accesses into single-beat
// 64-bit AXI4 transactions, one transaction outstanding at a time.
module cl_tcdm2axi_bridge #(
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter int          AXI_DATA_WIDTH = 64,
  parameter int          AXI_ID_WIDTH   = 6,
  parameter int          AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // TCDM slave port
  input  logic                        tcdm_slave_req_i,
  input  logic [31:0]                 tcdm_slave_add_i,
  input  logic                        tcdm_slave_wen_i,
  input  logic [31:0]                 tcdm_slave_data_i,
  input  logic [3:0]                  tcdm_slave_be_i,
  output logic                        tcdm_slave_gnt_o,
  output logic                        tcdm_slave_r_valid_o,
  output logic [31:0]                 tcdm_slave_r_data_o,
  output logic                        tcdm_slave_r_err_o,
  // AXI AW
  output logic                        axi_master_aw_valid_o,
  input  logic                        axi_master_aw_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_master_aw_addr_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_master_aw_id_o,
  output logic [7:0]                  axi_master_aw_len_o,
  output logic [2:0]                  axi_master_aw_size_o,
  output logic [1:0]                  axi_master_aw_burst_o,
  output logic                        axi_master_aw_lock_o,
  output logic [3:0]                  axi_master_aw_cache_o,
  output logic [2:0]                  axi_master_aw_prot_o,
  output logic [3:0]                  axi_master_aw_qos_o,
  output logic [3:0]                  axi_master_aw_region_o,
  output logic [AXI_USER_WIDTH-1:0]   axi_master_aw_user_o,
  // AXI W
  output logic                        axi_master_w_valid_o,
  input  logic                        axi_master_w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   axi_master_w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_master_w_strb_o,
  output logic                        axi_master_w_last_o,
  output logic [AXI_USER_WIDTH-1:0]   axi_master_w_user_o,
  // AXI B
  input  logic                        axi_master_b_valid_i,
  output logic                        axi_master_b_ready_o,
  input  logic [1:0]                  axi_master_b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_master_b_id_i,
  input  logic [AXI_USER_WIDTH-1:0]   axi_master_b_user_i,
  // AXI AR
  output logic                        axi_master_ar_valid_o,
  input  logic                        axi_master_ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_master_ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_master_ar_id_o,
  output logic [7:0]                  axi_master_ar_len_o,
  output logic [2:0]                  axi_master_ar_size_o,
  output logic [1:0]                  axi_master_ar_burst_o,
  output logic                        axi_master_ar_lock_o,
  output logic [3:0]                  axi_master_ar_cache_o,
  output logic [2:0]                  axi_master_ar_prot_o,
  output logic [3:0]                  axi_master_ar_qos_o,
  output logic [3:0]                  axi_master_ar_region_o,
  output logic [AXI_USER_WIDTH-1:0]   axi_master_ar_user_o,
  // AXI R
  input  logic                        axi_master_r_valid_i,
  output logic                        axi_master_r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_master_r_data_i,
  input  logic [1:0]                  axi_master_r_resp_i,
  input  logic                        axi_master_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_master_r_id_i,
  input  logic [AXI_USER_WIDTH-1:0]   axi_master_r_user_i,
  // status
  output logic                        busy_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WAIT_B = 3'd2,
    RD     = 3'd3,
    WAIT_R = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t      state, state_next;

  // latched TCDM request
  logic [31:0] add_q;
  logic        wen_q;
  logic [31:0] data_q;
  logic [3:0]  be_q;

  // transaction progress and captured response
  logic        aw_done, w_done;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        grant;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // response fields the bridge does not need (single ID, single beat)
  logic        unused_inputs;
  assign unused_inputs = ^{axi_master_b_id_i, axi_master_b_user_i, axi_master_b_resp_i[0],
                           axi_master_r_resp_i[0], axi_master_r_last_i,
                           axi_master_r_id_i, axi_master_r_user_i};

  // Grant is only offered in IDLE and never while reset is held.
  assign grant = (state == IDLE) && tcdm_slave_req_i && !rst_i;

  assign aw_hs = axi_master_aw_valid_o && axi_master_aw_ready_i;
  assign w_hs  = axi_master_w_valid_o  && axi_master_w_ready_i;
  assign b_hs  = axi_master_b_valid_i  && axi_master_b_ready_o;
  assign ar_hs = axi_master_ar_valid_o && axi_master_ar_ready_i;
  assign r_hs  = axi_master_r_valid_i  && axi_master_r_ready_o;

  // Control state: FSM register, done flags and captured response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs)  err_q   <= axi_master_b_resp_i[1];
      if (r_hs) begin
        err_q   <= axi_master_r_resp_i[1];
        rdata_q <= add_q[2] ? axi_master_r_data_i[63:32] : axi_master_r_data_i[31:0];
      end
    end
  end

  // Request latch: payload only, loaded on grant and held through the transaction.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      add_q  <= tcdm_slave_add_i;
      wen_q  <= tcdm_slave_wen_i;
      data_q <= tcdm_slave_data_i;
      be_q   <= tcdm_slave_be_i;
    end
  end

  // Next-state logic: a write waits for both AW and W done before expecting B.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (grant) state_next = tcdm_slave_wen_i ? RD : WR;
      WR:     if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WAIT_B;
      WAIT_B: if (axi_master_b_valid_i) state_next = RESP;
      RD:     if (axi_master_ar_ready_i) state_next = WAIT_R;
      WAIT_R: if (axi_master_r_valid_i) state_next = RESP;
      RESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // TCDM side
  assign tcdm_slave_gnt_o     = grant;
  assign tcdm_slave_r_valid_o = (state == RESP);
  assign tcdm_slave_r_data_o  = rdata_q;
  assign tcdm_slave_r_err_o   = err_q;
  assign busy_o               = (state != IDLE);

  // Handshake controls; each AXI valid depends only on state and sticky flags,
  // so it holds steady until its own handshake.
  assign axi_master_aw_valid_o = (state == WR) && !aw_done;
  assign axi_master_w_valid_o  = (state == WR) && !w_done;
  assign axi_master_b_ready_o  = (state == WAIT_B);
  assign axi_master_ar_valid_o = (state == RD);
  assign axi_master_r_ready_o  = (state == WAIT_R);

  // Address and write payload
  assign axi_master_aw_addr_o = AXI_ADDR_WIDTH'(add_q);
  assign axi_master_ar_addr_o = AXI_ADDR_WIDTH'(add_q);
  assign axi_master_w_data_o  = AXI_DATA_WIDTH'({data_q, data_q});
  assign axi_master_w_strb_o  = AXI_DATA_WIDTH'(0) == 0 ?
                                (AXI_DATA_WIDTH/8)'(add_q[2] ? {be_q, 4'b0000} : {4'b0000, be_q}) :
                                '0;
  assign axi_master_w_last_o  = 1'b1;
  assign axi_master_w_user_o  = '0;

  // Fixed single-beat 32-bit INCR attributes
  assign axi_master_aw_id_o     = AXI_ID_WIDTH'(AXI_ID);
  assign axi_master_aw_len_o    = 8'd0;
  assign axi_master_aw_size_o   = 3'b010;
  assign axi_master_aw_burst_o  = 2'b01;
  assign axi_master_aw_lock_o   = 1'b0;
  assign axi_master_aw_cache_o  = 4'b0000;
  assign axi_master_aw_prot_o   = 3'b000;
  assign axi_master_aw_qos_o    = 4'b0000;
  assign axi_master_aw_region_o = 4'b0000;
  assign axi_master_aw_user_o   = '0;

  assign axi_master_ar_id_o     = AXI_ID_WIDTH'(AXI_ID);
  assign axi_master_ar_len_o    = 8'd0;
  assign axi_master_ar_size_o   = 3'b010;
  assign axi_master_ar_burst_o  = 2'b01;
  assign axi_master_ar_lock_o   = 1'b0;
  assign axi_master_ar_cache_o  = 4'b0000;
  assign axi_master_ar_prot_o   = 3'b000;
  assign axi_master_ar_qos_o    = 4'b0000;
  assign axi_master_ar_region_o = 4'b0000;
  assign axi_master_ar_user_o   = '0;

endmodule

// File: tb/tb_cl_tcdm2axi_bridge.sv
// Testbench for cl_tcdm2axi_bridge: an AXI slave with configurable ready and
// response latencies, checked against expectations derived from the bridge's
// address/data mapping rules and its closed-form handshake timing.
module tb_cl_tcdm2axi_bridge;

  logic        clk, rst_i;
  logic        req, wen, gnt, rvalid, rerr, busy;
  logic [31:0] add, data, rdata;
  logic [3:0]  be;

  logic        aw_valid, aw_ready, aw_lock, ar_valid, ar_ready, ar_lock;
  logic [31:0] aw_addr, ar_addr;
  logic [5:0]  aw_id, aw_user, ar_id, ar_user;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, aw_prot, ar_size, ar_prot;
  logic [1:0]  aw_burst, ar_burst;
  logic [3:0]  aw_cache, aw_qos, aw_region, ar_cache, ar_qos, ar_region;
  logic        w_valid, w_ready, w_last;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic [5:0]  w_user;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic        r_valid, r_ready, r_last;
  logic [63:0] r_data;
  logic [1:0]  r_resp;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // observations from the last run_txn
  int          obs_gnt_cyc, obs_gnt_cnt, obs_rv_cyc, obs_rv_cnt;
  int          obs_aw_hs, obs_w_hs, obs_ar_hs, obs_b_hs, obs_aw_vcyc, obs_w_vcyc;
  int          stab_err;
  logic        obs_timeout, obs_err, obs_wlast;
  logic [31:0] obs_rdata, obs_aw_addr, obs_ar_addr;
  logic [63:0] obs_wdata;
  logic [7:0]  obs_strb;
  logic [40:0] obs_aw_fields, obs_ar_fields;

  localparam logic [40:0] CONST_FIELDS = {8'd0, 3'd2, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0, 6'd5};

  cl_tcdm2axi_bridge #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(6),
                       .AXI_USER_WIDTH(6), .AXI_ID(5)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .tcdm_slave_req_i(req), .tcdm_slave_add_i(add), .tcdm_slave_wen_i(wen),
    .tcdm_slave_data_i(data), .tcdm_slave_be_i(be), .tcdm_slave_gnt_o(gnt),
    .tcdm_slave_r_valid_o(rvalid), .tcdm_slave_r_data_o(rdata), .tcdm_slave_r_err_o(rerr),
    .axi_master_aw_valid_o(aw_valid), .axi_master_aw_ready_i(aw_ready),
    .axi_master_aw_addr_o(aw_addr), .axi_master_aw_id_o(aw_id), .axi_master_aw_len_o(aw_len),
    .axi_master_aw_size_o(aw_size), .axi_master_aw_burst_o(aw_burst), .axi_master_aw_lock_o(aw_lock),
    .axi_master_aw_cache_o(aw_cache), .axi_master_aw_prot_o(aw_prot), .axi_master_aw_qos_o(aw_qos),
    .axi_master_aw_region_o(aw_region), .axi_master_aw_user_o(aw_user),
    .axi_master_w_valid_o(w_valid), .axi_master_w_ready_i(w_ready), .axi_master_w_data_o(w_data),
    .axi_master_w_strb_o(w_strb), .axi_master_w_last_o(w_last), .axi_master_w_user_o(w_user),
    .axi_master_b_valid_i(b_valid), .axi_master_b_ready_o(b_ready), .axi_master_b_resp_i(b_resp),
    .axi_master_b_id_i(6'd5), .axi_master_b_user_i(6'd0),
    .axi_master_ar_valid_o(ar_valid), .axi_master_ar_ready_i(ar_ready),
    .axi_master_ar_addr_o(ar_addr), .axi_master_ar_id_o(ar_id), .axi_master_ar_len_o(ar_len),
    .axi_master_ar_size_o(ar_size), .axi_master_ar_burst_o(ar_burst), .axi_master_ar_lock_o(ar_lock),
    .axi_master_ar_cache_o(ar_cache), .axi_master_ar_prot_o(ar_prot), .axi_master_ar_qos_o(ar_qos),
    .axi_master_ar_region_o(ar_region), .axi_master_ar_user_o(ar_user),
    .axi_master_r_valid_i(r_valid), .axi_master_r_ready_o(r_ready), .axi_master_r_data_i(r_data),
    .axi_master_r_resp_i(r_resp), .axi_master_r_last_i(1'b1), .axi_master_r_id_i(6'd5),
    .axi_master_r_user_i(6'd0),
    .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // One TCDM transaction against an AXI slave whose readies come after
  // *_lat cycles of valid and whose B/R arrives rsp_lat cycles after the
  // cycle following the last request handshake.
  task automatic run_txn(input logic t_wen, input logic [31:0] t_add, input logic [31:0] t_data,
                         input logic [3:0] t_be, input int aw_lat, input int w_lat, input int ar_lat,
                         input int rsp_lat, input logic [1:0] t_resp, input logic [63:0] t_rd64,
                         input logic hold);
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, rsp_cnt = 0;
    logic granted = 0, rsp_pend = 0, aw_seen = 0, w_seen = 0, fin = 0;
    logic aw_prev = 0, w_prev = 0, ar_prev = 0;
    logic [31:0] aw_a_prev = '0, ar_a_prev = '0;
    logic [63:0] w_d_prev = '0;
    logic [7:0]  w_s_prev = '0;
    obs_gnt_cyc = -1; obs_gnt_cnt = 0; obs_rv_cyc = -1; obs_rv_cnt = 0;
    obs_aw_hs = 0; obs_w_hs = 0; obs_ar_hs = 0; obs_b_hs = 0; obs_aw_vcyc = 0; obs_w_vcyc = 0;
    stab_err = 0; obs_timeout = 1; obs_err = 0; obs_rdata = '0; obs_wlast = 0;
    obs_aw_addr = '0; obs_ar_addr = '0; obs_wdata = '0; obs_strb = '0;
    obs_aw_fields = '0; obs_ar_fields = '0;
    for (int k = 0; k < 100 && !fin; k++) begin
      @(negedge clk);
      if (!granted || hold) begin
        req = 1'b1; wen = t_wen; add = t_add; data = t_data; be = t_be;
      end else begin
        req = 1'b0; add = $urandom; data = $urandom; be = 4'($urandom);
      end
      #1;
      aw_ready = (aw_cnt >= aw_lat);
      w_ready  = (w_cnt >= w_lat);
      ar_ready = (ar_cnt >= ar_lat);
      b_valid  = rsp_pend && !t_wen && (rsp_cnt == 0);
      r_valid  = rsp_pend &&  t_wen && (rsp_cnt == 0);
      b_resp   = t_resp;
      r_resp   = t_resp;
      r_data   = t_rd64;
      #1;
      // valid-hold: a pending valid may neither drop nor change payload
      if (aw_prev && (!aw_valid || aw_addr !== aw_a_prev)) stab_err++;
      if (w_prev && (!w_valid || w_data !== w_d_prev || w_strb !== w_s_prev)) stab_err++;
      if (ar_prev && (!ar_valid || ar_addr !== ar_a_prev)) stab_err++;
      aw_prev = aw_valid && !aw_ready; aw_a_prev = aw_addr;
      w_prev  = w_valid && !w_ready;   w_d_prev = w_data; w_s_prev = w_strb;
      ar_prev = ar_valid && !ar_ready; ar_a_prev = ar_addr;
      if (rsp_pend) begin
        if ((b_valid && b_ready) || (r_valid && r_ready)) rsp_pend = 0;
        else if (rsp_cnt > 0) rsp_cnt--;
      end
      if (b_valid && b_ready) obs_b_hs++;
      if (aw_valid) begin
        obs_aw_vcyc++; aw_cnt++;
        if (aw_ready) begin
          obs_aw_hs++; aw_seen = 1; obs_aw_addr = aw_addr;
          obs_aw_fields = {aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_user, aw_id};
        end
      end
      if (w_valid) begin
        obs_w_vcyc++; w_cnt++;
        if (w_ready) begin
          obs_w_hs++; w_seen = 1; obs_wdata = w_data; obs_strb = w_strb; obs_wlast = w_last;
        end
      end
      if (ar_valid) begin
        ar_cnt++;
        if (ar_ready) begin
          obs_ar_hs++; obs_ar_addr = ar_addr; rsp_pend = 1; rsp_cnt = rsp_lat;
          obs_ar_fields = {ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_id};
        end
      end
      if (!t_wen && aw_seen && w_seen && (aw_valid || w_valid)) begin
        rsp_pend = 1; rsp_cnt = rsp_lat;
      end
      if (gnt) begin
        obs_gnt_cnt++;
        if (!granted) begin granted = 1; obs_gnt_cyc = cyc; end
      end
      if (rvalid) begin
        obs_rv_cnt++; obs_rv_cyc = cyc; obs_rdata = rdata; obs_err = rerr;
        obs_timeout = 0; fin = 1;
      end
    end
    aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
    if (!hold) req = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req = 1'b1; wen = 1'b1; add = 32'h0; data = '0; be = '0;
    aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
    b_resp = '0; r_resp = '0; r_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, gnt, rvalid, busy} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {aw_valid, w_valid, ar_valid, b_ready, r_ready, gnt, rvalid, busy});
    end
    rst_i = 1'b0; req = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({busy, rvalid} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle: got busy/rvalid=%b want 00", {busy, rvalid});
    end
  endtask

  task automatic test_read_example();
    run_txn(1'b1, 32'h1000_0004, 32'h0, 4'hF, 0, 0, 0, 0, 2'b00, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    n_checks++;
    if (obs_ar_addr !== 32'h1000_0004) begin n_err++; $display("FAIL rd_ar_addr: got %h want 10000004", obs_ar_addr); end
    n_checks++;
    if (obs_rdata !== 32'hAAAA_BBBB) begin n_err++; $display("FAIL rd_data: got %h want aaaabbbb", obs_rdata); end
    n_checks++;
    if (obs_err !== 1'b0) begin n_err++; $display("FAIL rd_err: got %b want 0", obs_err); end
    n_checks++;
    if (obs_timeout || obs_rv_cyc - obs_gnt_cyc != 3) begin
      n_err++; $display("FAIL rd_latency: got %0d want 3 (timeout=%b)", obs_rv_cyc - obs_gnt_cyc, obs_timeout);
    end
    n_checks++;
    if (obs_ar_fields !== CONST_FIELDS) begin n_err++; $display("FAIL rd_ar_fields: got %h want %h", obs_ar_fields, CONST_FIELDS); end
  endtask

  task automatic test_write_example();
    run_txn(1'b0, 32'h0000_0008, 32'h1234_5678, 4'b0011, 0, 0, 0, 0, 2'b00, 64'h0, 1'b0);
    n_checks++;
    if (obs_strb !== 8'h03) begin n_err++; $display("FAIL wr_strb: got %h want 03", obs_strb); end
    n_checks++;
    if (obs_wdata !== 64'h1234_5678_1234_5678) begin n_err++; $display("FAIL wr_data: got %h want 1234567812345678", obs_wdata); end
    n_checks++;
    if ({obs_wlast, obs_aw_addr} !== {1'b1, 32'h8}) begin n_err++; $display("FAIL wr_last_addr: got %b/%h want 1/00000008", obs_wlast, obs_aw_addr); end
    n_checks++;
    if (obs_timeout || obs_rv_cnt != 1 || obs_b_hs != 1 || obs_rdata !== 32'h0) begin
      n_err++; $display("FAIL wr_resp: got rv=%0d b=%0d data=%h want rv=1 b=1 data=0", obs_rv_cnt, obs_b_hs, obs_rdata);
    end
    n_checks++;
    if (obs_aw_fields !== CONST_FIELDS) begin n_err++; $display("FAIL wr_aw_fields: got %h want %h", obs_aw_fields, CONST_FIELDS); end
  endtask

  task automatic test_w_delay();
    run_txn(1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 4'b1001, 0, 4, 0, 0, 2'b00, 64'h0, 1'b0);
    n_checks++;
    if (obs_aw_vcyc != 1 || obs_w_vcyc != 5) begin
      n_err++; $display("FAIL wdly_valid_cycles: got aw=%0d w=%0d want aw=1 w=5", obs_aw_vcyc, obs_w_vcyc);
    end
    n_checks++;
    if (stab_err != 0) begin n_err++; $display("FAIL wdly_stable: got %0d violations want 0", stab_err); end
    n_checks++;
    if (obs_b_hs != 1 || obs_strb !== 8'h90) begin
      n_err++; $display("FAIL wdly_b_strb: got b=%0d strb=%h want b=1 strb=90", obs_b_hs, obs_strb);
    end
    n_checks++;
    if (obs_timeout || obs_rv_cyc - obs_gnt_cyc != 7) begin
      n_err++; $display("FAIL wdly_latency: got %0d want 7", obs_rv_cyc - obs_gnt_cyc);
    end
  endtask

  task automatic test_slverr_back_to_back();
    int first_rv;
    run_txn(1'b1, 32'h0000_0020, 32'h0, 4'hF, 0, 0, 1, 1, 2'b10, 64'h1111_2222_3333_4444, 1'b1);
    first_rv = obs_rv_cyc;
    n_checks++;
    if ({obs_err, obs_rdata} !== {1'b1, 32'h3333_4444}) begin
      n_err++; $display("FAIL slverr_resp: got err=%b data=%h want err=1 data=33334444", obs_err, obs_rdata);
    end
    n_checks++;
    if (obs_gnt_cnt != 1) begin n_err++; $display("FAIL b2b_busy_gnt: got %0d grants want 1", obs_gnt_cnt); end
    run_txn(1'b1, 32'h0000_0024, 32'h0, 4'hF, 0, 0, 0, 0, 2'b00, 64'h5555_6666_7777_8888, 1'b0);
    n_checks++;
    if (obs_gnt_cyc != first_rv + 1) begin
      n_err++; $display("FAIL b2b_next_gnt: got cycle %0d want %0d", obs_gnt_cyc, first_rv + 1);
    end
    n_checks++;
    if ({obs_err, obs_rdata} !== {1'b0, 32'h5555_6666}) begin
      n_err++; $display("FAIL b2b_second: got err=%b data=%h want err=0 data=55556666", obs_err, obs_rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_rv = 0;
    @(negedge clk);
    req = 1; wen = 0; add = 32'h40; data = 32'hCAFE_F00D; be = 4'hF;
    aw_ready = 1; w_ready = 1; b_valid = 0;
    #1;
    n_checks++;
    if (gnt !== 1'b1) begin n_err++; $display("FAIL rstmid_gnt: got %b want 1", gnt); end
    @(negedge clk); req = 0; #1;
    @(negedge clk); #1;
    n_checks++;
    if (b_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_waitb: got b_ready=%b want 1", b_ready); end
    rst_i = 1;
    @(negedge clk); req = 1; #1;
    n_checks++;
    if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, gnt, rvalid, busy} !== 8'h00) begin
      n_err++; $display("FAIL rstmid_outputs: got %b want 00000000",
                        {aw_valid, w_valid, ar_valid, b_ready, r_ready, gnt, rvalid, busy});
    end
    rst_i = 0; req = 0; aw_ready = 0; w_ready = 0; b_valid = 1; b_resp = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      if (rvalid || b_ready || busy) saw_rv = 1;
    end
    b_valid = 0;
    n_checks++;
    if (saw_rv !== 1'b0) begin n_err++; $display("FAIL rstmid_late_b: got activity=1 want 0"); end
    run_txn(1'b1, 32'h0000_0044, 32'h0, 4'hF, 0, 0, 0, 0, 2'b00, 64'h9999_AAAA_BBBB_CCCC, 1'b0);
    n_checks++;
    if (obs_timeout || obs_rdata !== 32'h9999_AAAA || obs_rv_cnt != 1) begin
      n_err++; $display("FAIL rstmid_recover: got data=%h rv=%0d want data=9999aaaa rv=1", obs_rdata, obs_rv_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic        t_wen  = 1'($urandom);
      logic [31:0] t_add  = $urandom;
      logic [31:0] t_data = $urandom;
      logic [3:0]  t_be   = 4'($urandom);
      int          awl = $urandom_range(0, 3), wl = $urandom_range(0, 3);
      int          arl = $urandom_range(0, 3), rl = $urandom_range(0, 3);
      logic [1:0]  t_rsp  = 2'($urandom);
      logic [63:0] t_rd   = {$urandom, $urandom};
      logic [31:0] e_rdata;
      int          e_lat, mx;
      mx = (awl > wl) ? awl : wl;
      e_lat   = t_wen ? 3 + arl + rl : 3 + mx + rl;
      e_rdata = !t_wen ? 32'h0 : (t_add[2] ? t_rd[63:32] : t_rd[31:0]);
      run_txn(t_wen, t_add, t_data, t_be, awl, wl, arl, rl, t_rsp, t_rd, 1'b0);
      n_checks++;
      if (obs_timeout || obs_rv_cnt != 1 || obs_rv_cyc - obs_gnt_cyc != e_lat ||
          obs_rdata !== e_rdata || obs_err !== t_rsp[1] || stab_err != 0) begin
        n_err++;
        $display("FAIL rand_%0d_resp: got lat=%0d data=%h err=%b rv=%0d stab=%0d want lat=%0d data=%h err=%b rv=1 stab=0",
                 i, obs_rv_cyc - obs_gnt_cyc, obs_rdata, obs_err, obs_rv_cnt, stab_err, e_lat, e_rdata, t_rsp[1]);
      end
      n_checks++;
      if (t_wen) begin
        if (obs_ar_addr !== t_add || obs_ar_hs != 1 || obs_aw_hs != 0) begin
          n_err++; $display("FAIL rand_%0d_ar: got addr=%h ar=%0d aw=%0d want addr=%h ar=1 aw=0",
                            i, obs_ar_addr, obs_ar_hs, obs_aw_hs, t_add);
        end
      end else begin
        if (obs_aw_addr !== t_add || obs_wdata !== {t_data, t_data} ||
            obs_strb !== (t_add[2] ? {t_be, 4'b0} : {4'b0, t_be}) || obs_b_hs != 1 || obs_ar_hs != 0) begin
          n_err++; $display("FAIL rand_%0d_w: got addr=%h data=%h strb=%h b=%0d want addr=%h data=%h strb=%h b=1",
                            i, obs_aw_addr, obs_wdata, obs_strb, obs_b_hs, t_add, {t_data, t_data},
                            (t_add[2] ? {t_be, 4'b0} : {4'b0, t_be}));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_example();
    test_write_example();
    test_w_delay();
    test_slverr_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
